serial_subtractor: RTL and testbench

- Bit-serial WIDTH-bit subtractor; computes DIFF = A - B, LSB first, one bit per clock, using a single full-subtractor cell and a borrow flip-flop.
- It is the inverse-operation counterpart to the team's parallel 8-bit ripple adder.
- It is the area-minimal arithmetic option for control-path use.
- A start/busy/done handshake frames each operation. Results are held until the next completion.

---
 rtl/serial_subtractor.sv | 93 +++++++++
 tb/tb_serial_subtractor.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: DIFF = A - B, one bit per clock, LSB first,
// built from a single full-subtractor cell and a borrow flip-flop.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] DIFF,
    output logic             BORROW
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] res_reg;
    logic [CW-1:0]    cnt;
    logic             br;

    // Full-subtractor cell operating on the current LSBs and the stored borrow.
    logic d;
    logic br_next;
    assign d       = a_reg[0] ^ b_reg[0] ^ br;
    assign br_next = (~a_reg[0] & b_reg[0]) | (~(a_reg[0] ^ b_reg[0]) & br);

    // NOTE: every state bit here is updated with <= so all registers sample
    // pre-edge values; using = would let later lines see already-shifted data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a_reg   <= '0;
            b_reg   <= '0;
            res_reg <= '0;
            cnt     <= '0;
            br      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            DIFF    <= '0;
            BORROW  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= A;
                        b_reg <= B;
                        br    <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    a_reg   <= a_reg >> 1;
                    b_reg   <= b_reg >> 1;
                    res_reg <= {d, res_reg[WIDTH-1:1]};
                    br      <= br_next;
                    cnt     <= cnt + CW'(1);
                    // Results are published only here, so partial sums never leak out.
                    if (cnt == LAST_BIT) begin
                        DIFF   <= {d, res_reg[WIDTH-1:1]};
                        BORROW <= br_next;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed vectors, back-to-back,
// mid-operation reset and a random sweep, all against a cycle-level model.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .A      (a_in),
        .B      (b_in),
        .busy   (busy),
        .done   (done),
        .DIFF   (diff),
        .BORROW (borrow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Reference model: result computed by plain wide arithmetic at accept time,
    // revealed after W busy cycles, then one done cycle, then idle again.
    int           m_phase = 0;   // 0 idle, 1 busy, 2 done
    int           m_left  = 0;
    logic [W:0]   m_pend  = '0;
    logic         m_busy  = 1'b0;
    logic         m_done  = 1'b0;
    logic [W-1:0] m_diff  = '0;
    logic         m_borrow = 1'b0;
    bit           cmp_en  = 1'b0;

    always @(posedge clk) begin
        cycle++;
        if (rst) begin
            m_phase = 0; m_busy = 0; m_done = 0; m_diff = '0; m_borrow = 0;
            cmp_en  = 1'b1;
        end else if (m_phase == 0) begin
            if (start) begin
                m_pend  = {1'b0, a_in} - {1'b0, b_in};
                m_left  = W;
                m_busy  = 1'b1;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_left--;
            if (m_left == 0) begin
                {m_borrow, m_diff} = m_pend;
                m_busy  = 1'b0;
                m_done  = 1'b1;
                m_phase = 2;
            end
        end else begin
            m_done  = 1'b0;
            m_phase = 0;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("busy",   32'(busy),   32'(m_busy));
            check("done",   32'(done),   32'(m_done));
            check("diff",   32'(diff),   32'(m_diff));
            check("borrow", 32'(borrow), 32'(m_borrow));
            check("busy_and_done_exclusive", 32'(busy & done), 32'(0));
        end
    end

    // One operation from idle: counts busy cycles and checks the done-cycle outputs.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_diff, input logic exp_borrow);
        int busy_cnt = 0;
        int guard    = 0;
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!done && guard < 40) begin
            busy_cnt += int'(busy);
            guard++;
            @(negedge clk);
        end
        check("done_seen", 32'(done), 32'(1));
        check("busy_cycles", 32'(busy_cnt), 32'(W));
        check("op_diff", 32'(diff), 32'(exp_diff));
        check("op_borrow", 32'(exp_borrow), 32'(borrow));
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'(0));
    endtask

    initial begin
        int t_prev;
        int n_done;
        int guard;
        int bcnt;
        logic [W-1:0] ra, rb;
        logic [W:0]   full;

        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(busy), 32'(0));
        check("reset_done", 32'(done), 32'(0));
        check("reset_diff", 32'(diff), 32'(0));
        check("reset_borrow", 32'(borrow), 32'(0));
        rst = 1'b0;

        run_op(8'd220, 8'd120, 8'd100, 1'b0);
        run_op(8'd17,  8'd135, 8'd138, 1'b1);
        run_op(8'd255, 8'd2,   8'd253, 1'b0);
        run_op(8'd2,   8'd255, 8'd3,   1'b1);
        run_op(8'd0,   8'd0,   8'd0,   1'b0);
        run_op(8'd0,   8'd1,   8'hFF,  1'b1);

        // Held start: done every W+2 cycles; mid-busy operand scrambles are ignored.
        @(negedge clk);
        a_in = 8'd100; b_in = 8'd50; start = 1'b1;
        n_done = 0; t_prev = 0; guard = 0; bcnt = 0;
        while (n_done < 3 && guard < 100) begin
            @(negedge clk);
            guard++;
            if (busy) begin
                bcnt++;
                if (bcnt == 3) begin a_in = 8'd7;   b_in = 8'd200; end
                if (bcnt == 6) begin a_in = 8'd100; b_in = 8'd50;  end
            end
            if (done) begin
                bcnt = 0;
                check("b2b_diff", 32'(diff), 32'(50));
                check("b2b_borrow", 32'(borrow), 32'(0));
                if (n_done > 0) check("b2b_period", 32'(cycle - t_prev), 32'(W + 2));
                t_prev = cycle;
                n_done++;
            end
        end
        check("b2b_count", 32'(n_done), 32'(3));
        start = 1'b0;
        repeat (W + 3) @(negedge clk);

        // Reset on the 4th busy cycle aborts with no done pulse.
        a_in = 8'd200; b_in = 8'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_busy_before", 32'(busy), 32'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_done", 32'(done), 32'(0));
        check("abort_diff", 32'(diff), 32'(0));
        check("abort_borrow", 32'(borrow), 32'(0));
        n_done = 0;
        repeat (2 * W) begin
            @(negedge clk);
            n_done += int'(done);
        end
        check("abort_no_done", 32'(n_done), 32'(0));

        for (int i = 0; i < 1000; i++) begin
            ra   = W'($urandom);
            rb   = W'($urandom);
            full = {1'b0, ra} - {1'b0, rb};
            run_op(ra, rb, full[W-1:0], full[W]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
